bus_arbiter_sm: RTL and testbench
=================================

# bus_arbiter_sm

Parametrised bus-transaction arbiter and tracker for the miniRV core. It multiplexes NUM_CH requesters (e.g. ifetch, LSU, debug) onto the single downstream bus using round-robin arbitration. A two-state IDLE/WAIT machine holds one transaction outstanding at a time. It adds a wait-cycle timeout that returns an error response to the owning channel if the bus never answers.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels; must be ≥ 2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT, 255: WAIT cycles tolerated before an error response; 0 disables the timeout.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ch_req_valid  in  NUM_CH  per-channel request.
- ch_req_ready  out  NUM_CH  one-hot accept, combinational, IDLE only.
- ch_req_addr  in  NUM_CH*ADDR_W  packed, channel i at [i*ADDR_W +: ADDR_W].
- ch_req_wen  in  NUM_CH  1 = write.
- ch_req_wdata  in  NUM_CH*DATA_W  packed like addr.
- ch_resp_valid  out  NUM_CH  one-hot response strobe to the owner.
- ch_resp_rdata  out  DATA_W  shared read data; 0 on error.
- ch_resp_err  out  1  qualifies ch_resp_valid; 1 = timeout.
- bus_req_valid  out  1  one-cycle request pulse.
- bus_req_addr / bus_req_wen / bus_req_wdata  out  ADDR_W / 1 / DATA_W  latched request.
- bus_resp_valid  in  1  bus response strobe.
- bus_resp_rdata  in  DATA_W  bus read data.
- busy  out  1  state == BUS_WAIT.

## Operation
- States: BUS_IDLE, BUS_WAIT. Reset → BUS_IDLE.
- In BUS_IDLE with any ch_req_valid:
  - Round-robin winner g: first valid channel searching from last_grant+1, wrapping.
  - ch_req_ready[g]=1 in the same cycle.
  - At the edge: latch addr/wen/wdata of g, owner←g, last_grant←g, wait_cnt←0, go to BUS_WAIT.
- In BUS_IDLE with no request: stay. bus_resp_valid is ignored; stray or late responses are dropped.
- In BUS_WAIT:
  - bus_req_valid=1 only in the first WAIT cycle.
  - bus_req_addr/wen/wdata hold their latched values throughout WAIT. They retain the last values in IDLE.
- Response in BUS_WAIT with bus_resp_valid=1:
  - ch_resp_valid[owner]=1, ch_resp_err=0, ch_resp_rdata=bus_resp_rdata, all combinational.
  - Next state BUS_IDLE.
- Timeout in BUS_WAIT: when bus_resp_valid=0, TIMEOUT≠0 and wait_cnt==TIMEOUT:
  - ch_resp_valid[owner]=1, ch_resp_err=1, rdata=0.
  - Next state BUS_IDLE.
- Otherwise in BUS_WAIT: wait_cnt saturating increment.
- Response and timeout in the same cycle: the response wins, err=0.
- wait_cnt width is $clog2(TIMEOUT+1), minimum 1. It resets to 0 on every WAIT entry.
- ch_req_ready, ch_resp_valid and ch_resp_err are all 0 in any cycle not listed above.
- Reset values:
  - state BUS_IDLE, last_grant NUM_CH-1 (channel 0 has first priority), owner 0, wait_cnt 0.
  - Latched request fields 0.
  - All outputs 0.
- Reset mid-WAIT abandons the transaction: no response is issued and the owner must re-request.

## Timing
- Cycle 0: accept (ready high).
- Cycle 1: bus_req_valid high. The earliest bus_resp_valid is accepted in this same cycle.
- Back-to-back: with the response in cycle N, the next accept can occur in cycle N+1.
- A zero-wait bus gives one transaction per 2 cycles.
- Timeout error is delivered in WAIT cycle TIMEOUT+1, i.e. TIMEOUT+1 cycles after the bus_req_valid cycle is counted as WAIT cycle 1.
- Combinational paths:
  - ch_req_valid → ch_req_ready.
  - bus_resp_valid/rdata → ch_resp_*.
  - No path exists from bus_resp_valid to bus_req_*.

## Structure
- BUS_IDLE/BUS_WAIT encodings come from the shared defs include. No local redefinition.
- Sub-module rr_arbiter (parameter N): purely combinational.
  - Inputs: req[N] and last_grant index.
  - Outputs: one-hot gnt and the gnt index.
  - This module is reused by any future multi-master arbitration.
- bus_arbiter_sm holds the state register, owner/last_grant registers, request latches and wait_cnt.

## Test plan
- Single request: NUM_CH=2, ch1 reads 0x100, bus answers in cycle 1 with 0xDEADBEEF → ready[1] in cycle 0, bus_req_valid pulse in cycle 1, resp_valid[1] in cycle 1, err=0, rdata=0xDEADBEEF, IDLE in cycle 2.
- Fairness: both channels held valid, bus answers after 2 cycles, 6 transactions → grant order 0,1,0,1,0,1. No grant occurs while busy=1.
- Timeout: TIMEOUT=3, ch0 writes 0x40 and the bus stays silent → resp_valid[0]=1, err=1, rdata=0 in the 4th WAIT cycle. A late bus_resp_valid 2 cycles later produces no ch_resp_valid.
- Tie: TIMEOUT=3, bus_resp_valid with rdata=0x5 in exactly the 4th WAIT cycle → err=0, rdata=0x5.
- Reset in WAIT: assert reset in WAIT cycle 2 → busy=0 and all outputs 0 immediately. After deassert, first grant goes to ch0 even with ch1 also valid.
- TIMEOUT=0: the bus stays silent for 1000 cycles → busy stays 1 and no response is issued. A response then completes normally.

Source files
------------

// File: rtl/bus_arbiter_sm_pkg.sv
// rtl/bus_arbiter_sm_pkg.sv - shared state encodings and sizing helpers for the bus arbiter
package bus_arbiter_sm_pkg;

  // Transaction tracker states: idle, or one transaction outstanding on the bus
  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_WAIT = 1'b1
  } bus_state_e;

  // Width of a counter that must reach timeout; never narrower than one bit
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/bus_arbiter_sm_rr_arbiter.sv
// rtl/bus_arbiter_sm_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Search from last_grant+1 upward with wrap; the first requester found wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = found;
  end

endmodule

// File: rtl/bus_arbiter_sm.sv
// rtl/bus_arbiter_sm.sv - round-robin bus arbiter with single-outstanding tracker and timeout
module bus_arbiter_sm
  import bus_arbiter_sm_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH-1:0]        ch_req_wen,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [DATA_W-1:0]        ch_resp_rdata,
  output logic                     ch_resp_err,
  output logic                     bus_req_valid,
  output logic [ADDR_W-1:0]        bus_req_addr,
  output logic                     bus_req_wen,
  output logic [DATA_W-1:0]        bus_req_wdata,
  input  logic                     bus_resp_valid,
  input  logic [DATA_W-1:0]        bus_resp_rdata,
  output logic                     busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bus_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [NUM_CH-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              timeout_hit;

  rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (ch_req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // Timeout fires in WAIT cycle TIMEOUT+1; TIMEOUT of zero waits forever
  assign timeout_hit   = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT));
  assign busy          = (state_q == BUS_WAIT);
  assign bus_req_valid = (state_q == BUS_WAIT) && (wait_cnt_q == '0);
  assign bus_req_addr  = addr_q;
  assign bus_req_wen   = wen_q;
  assign bus_req_wdata = wdata_q;

  // Next-state, grant and response logic; ready is held low while reset is asserted
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    ch_req_ready  = '0;
    ch_resp_valid = '0;
    ch_resp_err   = 1'b0;
    ch_resp_rdata = '0;
    case (state_q)
      BUS_IDLE: begin
        if ((|ch_req_valid) && !reset) begin
          ch_req_ready = gnt;
          owner_d      = gnt_idx;
          last_grant_d = gnt_idx;
          addr_d       = ch_req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wen_d        = ch_req_wen[gnt_idx];
          wdata_d      = ch_req_wdata[gnt_idx*DATA_W +: DATA_W];
          wait_cnt_d   = '0;
          state_d      = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (bus_resp_valid) begin
          ch_resp_valid[owner_q] = 1'b1;
          ch_resp_rdata          = bus_resp_rdata;
          state_d                = BUS_IDLE;
        end else if (timeout_hit) begin
          ch_resp_valid[owner_q] = 1'b1;
          ch_resp_err            = 1'b1;
          state_d                = BUS_IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // State, ownership, request latch and wait counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BUS_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_sm.sv
// tb/tb_bus_arbiter_sm.sv - directed self-checking bench for bus_arbiter_sm
module tb_bus_arbiter_sm;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                     clock;
  logic                     reset;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH-1:0]        ch_req_wen;
  logic [NUM_CH*DATA_W-1:0] ch_req_wdata;
  logic [DATA_W-1:0]        bus_resp_rdata;

  // TIMEOUT=3 instance
  logic [NUM_CH-1:0] a_req_valid, a_req_ready, a_resp_valid;
  logic [DATA_W-1:0] a_resp_rdata, a_req_wdata;
  logic [ADDR_W-1:0] a_req_addr;
  logic              a_resp_err, a_bus_valid, a_req_wen, a_resp_in, a_busy;

  // TIMEOUT=0 instance
  logic [NUM_CH-1:0] b_req_valid, b_req_ready, b_resp_valid;
  logic [DATA_W-1:0] b_resp_rdata, b_req_wdata;
  logic [ADDR_W-1:0] b_req_addr;
  logic              b_resp_err, b_bus_valid, b_req_wen, b_resp_in, b_busy;

  int checks = 0;
  int errors = 0;

  bus_arbiter_sm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(3)) u_dut_t3 (
    .clock(clock), .reset(reset),
    .ch_req_valid(a_req_valid), .ch_req_ready(a_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(a_resp_valid), .ch_resp_rdata(a_resp_rdata), .ch_resp_err(a_resp_err),
    .bus_req_valid(a_bus_valid), .bus_req_addr(a_req_addr), .bus_req_wen(a_req_wen),
    .bus_req_wdata(a_req_wdata), .bus_resp_valid(a_resp_in), .bus_resp_rdata(bus_resp_rdata),
    .busy(a_busy)
  );

  bus_arbiter_sm #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(0)) u_dut_t0 (
    .clock(clock), .reset(reset),
    .ch_req_valid(b_req_valid), .ch_req_ready(b_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(b_resp_valid), .ch_resp_rdata(b_resp_rdata), .ch_resp_err(b_resp_err),
    .bus_req_valid(b_bus_valid), .bus_req_addr(b_req_addr), .bus_req_wen(b_req_wen),
    .bus_req_wdata(b_req_wdata), .bus_resp_valid(b_resp_in), .bus_resp_rdata(bus_resp_rdata),
    .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
    ch_req_addr[ch*ADDR_W +: ADDR_W]  = addr;
    ch_req_wen[ch]                    = wen;
    ch_req_wdata[ch*DATA_W +: DATA_W] = wdata;
  endtask

  logic [NUM_CH-1:0] exp_oh;
  logic              any_resp;
  logic              all_busy;

  initial begin
    reset          = 1'b1;
    a_req_valid    = '0;
    b_req_valid    = '0;
    a_resp_in      = 1'b0;
    b_resp_in      = 1'b0;
    ch_req_addr    = '0;
    ch_req_wen     = '0;
    ch_req_wdata   = '0;
    bus_resp_rdata = '0;

    // Reset state, including ready held low while requests are present
    tick();
    tick();
    a_req_valid = 2'b11;
    settle();
    check("rst_busy", a_busy, 0);
    check("rst_ready", a_req_ready, 0);
    check("rst_bus_valid", a_bus_valid, 0);
    check("rst_addr", a_req_addr, 0);
    check("rst_resp_valid", a_resp_valid, 0);
    check("rst_rdata", a_resp_rdata, 0);
    a_req_valid = '0;
    tick();
    reset = 1'b0;

    // Single read from ch1, bus answers in the first WAIT cycle
    set_ch(1, 32'h100, 1'b0, 32'h0);
    a_req_valid = 2'b10;
    settle();
    check("single_ready", a_req_ready, 2'b10);
    check("single_busy0", a_busy, 0);
    tick();
    a_req_valid    = '0;
    a_resp_in      = 1'b1;
    bus_resp_rdata = 32'hDEADBEEF;
    settle();
    check("single_busy1", a_busy, 1);
    check("single_bus_valid", a_bus_valid, 1);
    check("single_bus_addr", a_req_addr, 32'h100);
    check("single_bus_wen", a_req_wen, 0);
    check("single_resp_valid", a_resp_valid, 2'b10);
    check("single_err", a_resp_err, 0);
    check("single_rdata", a_resp_rdata, 32'hDEADBEEF);
    tick();
    a_resp_in = 1'b0;
    settle();
    check("single_idle", a_busy, 0);
    check("single_bus_valid_off", a_bus_valid, 0);
    check("single_resp_off", a_resp_valid, 0);
    check("single_addr_retained", a_req_addr, 32'h100);

    // Fairness: both channels valid, response in WAIT cycle 2
    set_ch(0, 32'h200, 1'b0, 32'h0);
    set_ch(1, 32'h300, 1'b0, 32'h0);
    a_req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      check("fair_idle_busy", a_busy, 0);
      check("fair_grant", a_req_ready, exp_oh);
      tick();
      settle();
      check("fair_w1_ready", a_req_ready, 0);
      check("fair_w1_bus_valid", a_bus_valid, 1);
      check("fair_w1_addr", a_req_addr, (t % 2 == 0) ? 32'h200 : 32'h300);
      check("fair_w1_resp", a_resp_valid, 0);
      tick();
      a_resp_in      = 1'b1;
      bus_resp_rdata = 32'h1000 + t;
      settle();
      check("fair_w2_ready", a_req_ready, 0);
      check("fair_w2_bus_valid", a_bus_valid, 0);
      check("fair_w2_resp", a_resp_valid, exp_oh);
      check("fair_w2_rdata", a_resp_rdata, 32'h1000 + t);
      tick();
      a_resp_in = 1'b0;
    end
    a_req_valid = '0;

    // Timeout: ch0 writes 0x40 and the bus stays silent
    set_ch(0, 32'h40, 1'b1, 32'hCAFE0001);
    bus_resp_rdata = 32'hAAAA5555;
    a_req_valid    = 2'b01;
    settle();
    check("to_ready", a_req_ready, 2'b01);
    tick();
    a_req_valid = '0;
    settle();
    check("to_bus_addr", a_req_addr, 32'h40);
    check("to_bus_wen", a_req_wen, 1);
    check("to_bus_wdata", a_req_wdata, 32'hCAFE0001);
    for (int w = 1; w <= 3; w++) begin
      check("to_silent_resp", a_resp_valid, 0);
      check("to_silent_busy", a_busy, 1);
      tick();
    end
    check("to_resp_valid", a_resp_valid, 2'b01);
    check("to_err", a_resp_err, 1);
    check("to_rdata_zero", a_resp_rdata, 0);
    tick();
    check("to_idle", a_busy, 0);
    tick();
    a_resp_in      = 1'b1;
    bus_resp_rdata = 32'h77;
    settle();
    check("late_resp_dropped", a_resp_valid, 0);
    check("late_err", a_resp_err, 0);
    check("late_busy", a_busy, 0);
    tick();
    a_resp_in = 1'b0;

    // Response and timeout in the same cycle: response wins
    a_req_valid = 2'b10;
    settle();
    check("tie_ready", a_req_ready, 2'b10);
    tick();
    a_req_valid = '0;
    tick();
    tick();
    tick();
    a_resp_in      = 1'b1;
    bus_resp_rdata = 32'h5;
    settle();
    check("tie_resp_valid", a_resp_valid, 2'b10);
    check("tie_err", a_resp_err, 0);
    check("tie_rdata", a_resp_rdata, 32'h5);
    tick();
    a_resp_in = 1'b0;
    settle();
    check("tie_idle", a_busy, 0);

    // Reset in WAIT cycle 2 abandons the transaction and restores priority
    a_req_valid = 2'b01;
    settle();
    check("rw_ready", a_req_ready, 2'b01);
    tick();
    tick();
    reset       = 1'b1;
    a_req_valid = 2'b11;
    settle();
    check("rw_busy", a_busy, 0);
    check("rw_ready_rst", a_req_ready, 0);
    check("rw_resp", a_resp_valid, 0);
    check("rw_bus_valid", a_bus_valid, 0);
    check("rw_addr", a_req_addr, 0);
    check("rw_wen", a_req_wen, 0);
    check("rw_wdata", a_req_wdata, 0);
    tick();
    reset = 1'b0;
    settle();
    check("rw_first_grant", a_req_ready, 2'b01);
    tick();
    a_req_valid = '0;
    a_resp_in   = 1'b1;
    settle();
    check("rw_complete", a_resp_valid, 2'b01);
    tick();
    a_resp_in = 1'b0;

    // TIMEOUT=0: silent bus for 1000 cycles, then a normal completion
    set_ch(0, 32'h80, 1'b0, 32'h0);
    b_req_valid = 2'b01;
    settle();
    check("t0_ready", b_req_ready, 2'b01);
    tick();
    b_req_valid = '0;
    any_resp    = 1'b0;
    all_busy    = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      any_resp = any_resp | (|b_resp_valid);
      all_busy = all_busy & b_busy;
      tick();
    end
    check("t0_no_resp", any_resp, 0);
    check("t0_all_busy", all_busy, 1);
    b_resp_in      = 1'b1;
    bus_resp_rdata = 32'h1234;
    settle();
    check("t0_resp_valid", b_resp_valid, 2'b01);
    check("t0_err", b_resp_err, 0);
    check("t0_rdata", b_resp_rdata, 32'h1234);
    tick();
    b_resp_in = 1'b0;
    settle();
    check("t0_idle", b_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
